// File: rtl/tdc_data_tx.sv
// Buffered single-wire serial transmitter for TDC hit words: FIFO + framed shifter at CLK/BIT_DIV.
// Optional odd-parity bit is compiled in with `define TDC_TX_PARITY_EN.
module tdc_data_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int BIT_DIV    = 10
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          ENABLE,
  input  logic [DATA_WIDTH-1:0]         IN_DATA,
  input  logic                          IN_WRITE,
  output logic                          FIFO_FULL,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
  output logic [7:0]                    LOST_CNT,
  output logic                          BUSY,
  output logic                          DATA_OUT
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(BIT_DIV);
  localparam int IW = $clog2(DATA_WIDTH);

  localparam logic [TW-1:0] T_LAST = TW'(BIT_DIV - 1);
  localparam logic [IW-1:0] I_LAST = IW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_SHIFT  = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
`ifdef TDC_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
`endif

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic [TW-1:0]         tick;
  logic [2:0]            state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [IW-1:0]         bit_idx;
`ifdef TDC_TX_PARITY_EN
  logic                  parity;
`endif
  logic                  boundary, full, pop, push;

  // Pop only at a bit boundary from IDLE or the end of STOP; a full FIFO
  // still accepts a push in the same cycle because the pop frees a slot first.
  always_comb begin
    boundary = (tick == T_LAST);
    full     = (count == C_FULL);
    pop      = boundary && ENABLE && (count != '0) &&
               ((state == S_IDLE) || (state == S_STOP));
    push     = IN_WRITE && (!full || pop);
  end

  assign FIFO_FULL  = full;
  assign FIFO_COUNT = count;
  assign BUSY       = (state != S_IDLE);

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= IN_DATA;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      LOST_CNT <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (IN_WRITE && !push && (LOST_CNT != 8'hFF))
        LOST_CNT <= LOST_CNT + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      tick     <= '0;
      state    <= S_IDLE;
      shreg    <= '0;
      bit_idx  <= '0;
      DATA_OUT <= 1'b0;
`ifdef TDC_TX_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      tick <= boundary ? '0 : tick + 1'b1;
      if (boundary) begin
        case (state)
          S_IDLE, S_STOP: begin
            if (pop) begin
              state    <= S_START;
              DATA_OUT <= 1'b1;
              shreg    <= mem[rd_ptr];
`ifdef TDC_TX_PARITY_EN
              parity   <= ~(^mem[rd_ptr]);
`endif
            end else begin
              state    <= S_IDLE;
              DATA_OUT <= 1'b0;
            end
          end
          S_START: begin
            state    <= S_SHIFT;
            bit_idx  <= '0;
            DATA_OUT <= shreg[I_LAST];
          end
          S_SHIFT: begin
            // bit_idx counts payload bits already on the line
            if (bit_idx == I_LAST) begin
`ifdef TDC_TX_PARITY_EN
              state    <= S_PARITY;
              DATA_OUT <= parity;
`else
              state    <= S_STOP;
              DATA_OUT <= 1'b0;
`endif
            end else begin
              bit_idx  <= bit_idx + 1'b1;
              DATA_OUT <= shreg[I_LAST - bit_idx - 1'b1];
            end
          end
`ifdef TDC_TX_PARITY_EN
          S_PARITY: begin
            state    <= S_STOP;
            DATA_OUT <= 1'b0;
          end
`endif
          default: begin
            state    <= S_IDLE;
            DATA_OUT <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdc_data_tx.sv
// Self-checking bench for tdc_data_tx: queue-based line model compared every cycle,
// plus literal frame, overflow, saturation and reset expectations.
module tb_tdc_data_tx;
  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int BD    = 10;
`ifdef TDC_TX_PARITY_EN
  localparam int FL = DW + 3;
  localparam logic [FL-1:0] EXP_A5C3 = 19'b1_1010010111000011_1_0;
  localparam logic [FL-1:0] EXP_3C5A = 19'b1_0011110001011010_1_0;
`else
  localparam int FL = DW + 2;
  localparam logic [FL-1:0] EXP_A5C3 = 18'b1_1010010111000011_0;
  localparam logic [FL-1:0] EXP_3C5A = 18'b1_0011110001011010_0;
`endif

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          ENABLE = 1'b0;
  logic [DW-1:0] IN_DATA = '0;
  logic          IN_WRITE = 1'b0;
  logic          FIFO_FULL;
  logic [3:0]    FIFO_COUNT;
  logic [7:0]    LOST_CNT;
  logic          BUSY;
  logic          DATA_OUT;

  tdc_data_tx #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .BIT_DIV(BD)) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .IN_DATA(IN_DATA), .IN_WRITE(IN_WRITE),
    .FIFO_FULL(FIFO_FULL), .FIFO_COUNT(FIFO_COUNT), .LOST_CNT(LOST_CNT),
    .BUSY(BUSY), .DATA_OUT(DATA_OUT)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: FIFO as a queue, the line as a queue of per-cycle samples.
  logic [DW-1:0] m_fifo[$];
  bit            m_line[$];
  int            m_tick = 0;
  int            m_lost = 0;
  logic [DW-1:0] m_word;

  function automatic void add_bit(input bit b);
    for (int i = 0; i < BD; i++) m_line.push_back(b);
  endfunction

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_fifo.delete();
      m_line.delete();
      m_tick = 0;
      m_lost = 0;
    end else begin
      if (m_line.size() > 0) void'(m_line.pop_front());
      if (m_tick == BD - 1 && m_line.size() == 0 && ENABLE && m_fifo.size() > 0) begin
        m_word = m_fifo.pop_front();
        add_bit(1'b1);
        for (int i = DW - 1; i >= 0; i--) add_bit(m_word[i]);
`ifdef TDC_TX_PARITY_EN
        add_bit(~(^m_word));
`endif
        add_bit(1'b0);
      end
      if (IN_WRITE) begin
        if (m_fifo.size() < DEPTH) m_fifo.push_back(IN_DATA);
        else if (m_lost < 255) m_lost++;
      end
      m_tick = (m_tick + 1) % BD;
    end
  end

  always @(negedge CLK) begin
    if (!RESET) begin
      check("data_out",   32'(DATA_OUT),   (m_line.size() > 0) ? 32'(m_line[0]) : 32'd0);
      check("busy",       32'(BUSY),       32'(m_line.size() > 0));
      check("fifo_count", 32'(FIFO_COUNT), 32'(m_fifo.size()));
      check("fifo_full",  32'(FIFO_FULL),  32'(m_fifo.size() == DEPTH));
      check("lost_cnt",   32'(LOST_CNT),   32'(m_lost));
    end
  end

  task automatic cyc(input logic wr, input logic [DW-1:0] d);
    @(negedge CLK);
    IN_WRITE = wr;
    IN_DATA  = d;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_line.size() != 0 || m_fifo.size() != 0) && n < 30000) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 30000) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic frame_check(input string nm, input logic [FL-1:0] exp);
    int n = 0;
    int k = 0;
    while (!DATA_OUT && n < 3 * BD) begin
      @(negedge CLK);
      n++;
    end
    if (!DATA_OUT) begin
      check({nm, "_start_timeout"}, 32'd1, 32'd0);
      return;
    end
    while (BUSY && k < FL * BD + 20) begin
      if (k % BD == BD / 2 && k / BD < FL)
        check({nm, "_bit"}, 32'(DATA_OUT), 32'(exp[FL - 1 - k / BD]));
      @(negedge CLK);
      k++;
    end
    check({nm, "_len"}, 32'(k), 32'(FL * BD));
  endtask

  initial begin
    int n;
    ENABLE = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_data_out", 32'(DATA_OUT), 32'd0);
    check("rst_busy",     32'(BUSY), 32'd0);
    check("rst_count",    32'(FIFO_COUNT), 32'd0);
    check("rst_full",     32'(FIFO_FULL), 32'd0);
    check("rst_lost",     32'(LOST_CNT), 32'd0);
    #2 RESET = 1'b0;

    repeat (4) cyc(1'b0, '0);
    cyc(1'b1, 16'hA5C3);
    cyc(1'b0, '0);
    frame_check("a5c3", EXP_A5C3);
    wait_idle();
    check("a5c3_count", 32'(FIFO_COUNT), 32'd0);
    check("a5c3_line",  32'(DATA_OUT), 32'd0);

    cyc(1'b1, 16'h0001);
    cyc(1'b1, 16'hFFFF);
    cyc(1'b0, '0);
    wait_idle();

    @(negedge CLK);
    ENABLE = 1'b0;
    for (int i = 0; i < 10; i++) cyc(1'b1, 16'h1000 + 16'(i));
    cyc(1'b0, '0);
    check("ovf_full",  32'(FIFO_FULL), 32'd1);
    check("ovf_count", 32'(FIFO_COUNT), 32'd8);
    check("ovf_lost",  32'(LOST_CNT), 32'd2);

    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (m_tick != BD - 1 && n < 4 * BD);
    ENABLE   = 1'b1;
    IN_WRITE = 1'b1;
    IN_DATA  = 16'hBEEF;
    @(negedge CLK);
    IN_WRITE = 1'b0;
    check("pp_count", 32'(FIFO_COUNT), 32'd8);
    check("pp_lost",  32'(LOST_CNT), 32'd2);
    check("pp_busy",  32'(BUSY), 32'd1);
    wait_idle();

    @(negedge CLK);
    ENABLE = 1'b0;
    for (int i = 0; i < DEPTH + 300; i++) cyc(1'b1, 16'(i * 7));
    cyc(1'b0, '0);
    check("sat_lost", 32'(LOST_CNT), 32'd255);
    for (int i = 0; i < 5; i++) cyc(1'b1, 16'h5555);
    cyc(1'b0, '0);
    check("sat_hold", 32'(LOST_CNT), 32'd255);

    ENABLE = 1'b1;
    n = 0;
    while (!DATA_OUT && n < 3 * BD) begin
      @(negedge CLK);
      n++;
    end
    repeat (3 * BD) @(negedge CLK);
    check("pre_rst_busy", 32'(BUSY), 32'd1);
    #2 RESET = 1'b1;
    #1;
    check("mid_rst_data_out", 32'(DATA_OUT), 32'd0);
    check("mid_rst_busy",     32'(BUSY), 32'd0);
    check("mid_rst_count",    32'(FIFO_COUNT), 32'd0);
    check("mid_rst_full",     32'(FIFO_FULL), 32'd0);
    check("mid_rst_lost",     32'(LOST_CNT), 32'd0);
    @(negedge CLK);
    #2 RESET = 1'b0;
    repeat (3) cyc(1'b0, '0);
    cyc(1'b1, 16'h3C5A);
    cyc(1'b0, '0);
    frame_check("3c5a", EXP_3C5A);
    wait_idle();

    for (int i = 0; i < 5000; i++) begin
      @(negedge CLK);
      IN_WRITE = ($urandom_range(0, 29) == 0) || (!ENABLE && $urandom_range(0, 3) == 0);
      IN_DATA  = DW'($urandom);
      if ($urandom_range(0, 299) == 0) ENABLE = ~ENABLE;
    end
    @(negedge CLK);
    IN_WRITE = 1'b0;
    ENABLE   = 1'b1;
    wait_idle();
    repeat (2 * BD) @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
